// File: rtl/branch_predictor_btb_if.sv
// Predictor/pipeline bus: fetch lookup, resolved-branch update and flush.
// Statistics outputs exist only when BRANCH_PRED_STATS_EN is defined.
interface branch_predictor_btb_if;
  logic [31:0] current_PC;
  logic        predict_taken;
  logic [31:0] target_addr;
  logic        update_predictor;
  logic [31:0] update_addr;
  logic [31:0] update_target;
  logic        prediction;
  logic        branch_result;
  logic        flush;
`ifdef BRANCH_PRED_STATS_EN
  logic [31:0] stat_updates;
  logic [31:0] stat_mispredicts;
  logic [31:0] stat_hits;
`endif

  modport master (
    output current_PC, update_predictor, update_addr, update_target, prediction,
           branch_result, flush,
`ifdef BRANCH_PRED_STATS_EN
    input  stat_updates, stat_mispredicts, stat_hits,
`endif
    input  predict_taken, target_addr
  );

  modport slave (
    input  current_PC, update_predictor, update_addr, update_target, prediction,
           branch_result, flush,
`ifdef BRANCH_PRED_STATS_EN
    output stat_updates, stat_mispredicts, stat_hits,
`endif
    output predict_taken, target_addr
  );
endinterface

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with 2-bit saturating counters; zero-latency lookup.
// Optional update/mispredict/hit counters are enabled by BRANCH_PRED_STATS_EN.
module branch_predictor_btb #(
  parameter int unsigned ENTRIES = 16
) (
  input logic                   CLK,
  input logic                   RST,
  branch_predictor_btb_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = 30 - IDX_W;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, up_hit, lk_taken;

  assign lk_idx = bus.current_PC[IDX_W+1:2];
  assign lk_tag = bus.current_PC[31:IDX_W+2];
  assign up_idx = bus.update_addr[IDX_W+1:2];
  assign up_tag = bus.update_addr[31:IDX_W+2];

  assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign lk_taken = lk_hit & ctr_q[lk_idx][1];

  // Lookup reads the pre-update table contents; no write-to-read bypass.
  assign bus.predict_taken = lk_taken;
  assign bus.target_addr   = lk_taken ? target_q[lk_idx] : bus.current_PC + 32'd4;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= 32'd0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (bus.flush) begin
      // Flush only drops valid bits and wins over a same-cycle update.
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (bus.update_predictor) begin
      if (up_hit) begin
        if (bus.branch_result) begin
          if (ctr_q[up_idx] != 2'b11) ctr_q[up_idx] <= ctr_q[up_idx] + 2'b01;
          target_q[up_idx] <= bus.update_target;
        end else if (ctr_q[up_idx] != 2'b00) begin
          ctr_q[up_idx] <= ctr_q[up_idx] - 2'b01;
        end
      end else if (bus.branch_result) begin
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= bus.update_target;
        ctr_q[up_idx]    <= 2'b10;
      end
    end
  end

`ifdef BRANCH_PRED_STATS_EN
  logic [31:0] upd_cnt_q, mis_cnt_q, hit_cnt_q;

  // Counters observe every update strobe, even one dropped by flush.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      upd_cnt_q <= 32'd0;
      mis_cnt_q <= 32'd0;
      hit_cnt_q <= 32'd0;
    end else if (bus.update_predictor) begin
      if (upd_cnt_q != 32'hFFFF_FFFF) upd_cnt_q <= upd_cnt_q + 32'd1;
      if ((bus.prediction != bus.branch_result) && (mis_cnt_q != 32'hFFFF_FFFF)) begin
        mis_cnt_q <= mis_cnt_q + 32'd1;
      end
      if (up_hit && (hit_cnt_q != 32'hFFFF_FFFF)) hit_cnt_q <= hit_cnt_q + 32'd1;
    end
  end

  assign bus.stat_updates     = upd_cnt_q;
  assign bus.stat_mispredicts = mis_cnt_q;
  assign bus.stat_hits        = hit_cnt_q;
`endif
endmodule

// File: tb/tb_branch_predictor_btb.sv
// Bench for branch_predictor_btb: directed test-plan steps, then random traffic
// checked against a line-address reference model.
module tb_branch_predictor_btb;
  localparam int unsigned N = 16;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  branch_predictor_btb_if bus ();
  branch_predictor_btb #(.ENTRIES(N)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  int n_cmp = 0;
  int n_fail = 0;

  // Model: each slot remembers the full word address (PC>>2) of its branch.
  bit          m_valid [N];
  logic [29:0] m_line  [N];
  logic [31:0] m_tgt   [N];
  int          m_ctr   [N];
  longint      m_upd, m_mis, m_hit;

  function automatic int slot(input logic [31:0] pc);
    return int'((pc >> 2) % N);
  endfunction

  function automatic bit m_hits(input logic [31:0] pc);
    return m_valid[slot(pc)] && (m_line[slot(pc)] == pc[31:2]);
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    return m_hits(pc) && (m_ctr[slot(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_target(input logic [31:0] pc);
    return m_pred(pc) ? m_tgt[slot(pc)] : pc + 32'd4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0; m_line[i] = '0; m_tgt[i] = 32'd0; m_ctr[i] = 1;
    end
    m_upd = 0; m_mis = 0; m_hit = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: drive, compare combinational outputs mid-cycle, clock, update model.
  task automatic drive(input logic [31:0] pc, input bit upd, input logic [31:0] ua,
                       input logic [31:0] ut, input bit pred, input bit res, input bit fl,
                       input bit chk, input bit ept, input logic [31:0] etgt);
    int s;
    bus.current_PC = pc; bus.update_predictor = upd; bus.update_addr = ua;
    bus.update_target = ut; bus.prediction = pred; bus.branch_result = res; bus.flush = fl;
    #2;
    check("predict_taken", {31'd0, bus.predict_taken}, {31'd0, m_pred(pc)});
    check("target_addr", bus.target_addr, m_target(pc));
    if (chk) begin
      check("plan_predict_taken", {31'd0, bus.predict_taken}, {31'd0, ept});
      check("plan_target_addr", bus.target_addr, etgt);
    end
`ifdef BRANCH_PRED_STATS_EN
    check("stat_updates", bus.stat_updates, m_upd[31:0]);
    check("stat_mispredicts", bus.stat_mispredicts, m_mis[31:0]);
    check("stat_hits", bus.stat_hits, m_hit[31:0]);
`endif
    @(posedge CLK);
    s = slot(ua);
    if (upd) begin
      m_upd++;
      if (pred != res) m_mis++;
      if (m_hits(ua)) m_hit++;
    end
    if (fl) begin
      for (int i = 0; i < N; i++) m_valid[i] = 0;
    end else if (upd) begin
      if (m_hits(ua)) begin
        if (res) begin
          m_ctr[s] = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
          m_tgt[s] = ut;
        end else begin
          m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
        end
      end else if (res) begin
        m_valid[s] = 1; m_line[s] = ua[31:2]; m_tgt[s] = ut; m_ctr[s] = 2;
      end
    end
    #1;
  endtask

  task automatic lookc(input logic [31:0] pc, input bit ept, input logic [31:0] etgt);
    drive(pc, 0, 32'd0, 32'd0, 0, 0, 0, 1, ept, etgt);
  endtask

  task automatic upd(input logic [31:0] ua, input logic [31:0] ut, input bit res);
    drive(32'h0000_8000, 1, ua, ut, m_pred(ua), res, 0, 0, 0, 32'd0);
  endtask

  task automatic do_reset();
    bus.update_predictor = 0; bus.flush = 0;
    #1 RST = 1'b1;
    model_reset();
    @(posedge CLK); #1 RST = 1'b0; #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] pc, ua;
    bit u, f, r;
    bus.current_PC = 32'h0000_1000; bus.update_predictor = 0; bus.update_addr = 0;
    bus.update_target = 0; bus.prediction = 0; bus.branch_result = 0; bus.flush = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0; #1;

    // Reset state and allocation.
    lookc(32'h0000_1000, 0, 32'h0000_1004);
    upd(32'h1000, 32'h2000, 1);
    lookc(32'h0000_1000, 1, 32'h0000_2000);

    // Hysteresis and saturation at both ends.
    upd(32'h1000, 32'h2000, 1);
    upd(32'h1000, 32'h2000, 1);
    upd(32'h1000, 32'h2000, 0);
    lookc(32'h0000_1000, 1, 32'h0000_2000);
    upd(32'h1000, 32'h2000, 0);
    lookc(32'h0000_1000, 0, 32'h0000_1004);
    repeat (3) upd(32'h1000, 32'h2000, 0);
    upd(32'h1000, 32'h2000, 1);
    lookc(32'h0000_1000, 0, 32'h0000_1004);
    upd(32'h1000, 32'h2000, 1);
    lookc(32'h0000_1000, 1, 32'h0000_2000);

    // Aliasing on index 0 with a different tag.
    lookc(32'h0000_1040, 0, 32'h0000_1044);
    upd(32'h1040, 32'h3000, 1);
    lookc(32'h0000_1000, 0, 32'h0000_1004);
    lookc(32'h0000_1040, 1, 32'h0000_3000);

    // Same-cycle lookup and update: old target visible, new one next cycle.
    drive(32'h1040, 1, 32'h1040, 32'h4000, 1, 1, 0, 1, 1, 32'h0000_3000);
    lookc(32'h0000_1040, 1, 32'h0000_4000);
    lookc(32'h0000_1042, 1, 32'h0000_4000);

    // Flush beats a simultaneous allocating update.
    drive(32'h1040, 1, 32'h1080, 32'h5000, 0, 1, 1, 1, 1, 32'h0000_4000);
    lookc(32'h0000_1040, 0, 32'h0000_1044);
    lookc(32'h0000_1080, 0, 32'h0000_1084);
    upd(32'h1040, 32'h6000, 0);
    lookc(32'h0000_1040, 0, 32'h0000_1044);
    upd(32'h1040, 32'h6000, 1);
    lookc(32'h0000_1040, 1, 32'h0000_6000);
    lookc(32'hFFFF_FFFC, 0, 32'h0000_0000);

    // Reset asserted while an update is pending discards it.
    bus.current_PC = 32'h10C0; bus.update_predictor = 1; bus.update_addr = 32'h10C0;
    bus.update_target = 32'h7000; bus.branch_result = 1; bus.flush = 0;
    #2 RST = 1'b1;
    model_reset();
    @(posedge CLK); #1 RST = 1'b0; #1;
    lookc(32'h0000_10C0, 0, 32'h0000_10C4);
    lookc(32'h0000_1040, 0, 32'h0000_1044);

    // Random traffic over a small aliasing address pool.
    for (int k = 0; k < 400; k++) begin
      pc = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
         | 32'($urandom_range(0, 3));
      ua = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
      if ($urandom_range(0, 7) == 0) pc = pc | 32'hF000_0000;
      u = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 31) == 0);
      r = $urandom_range(0, 1) == 1;
      drive(pc, u, ua, $urandom, m_pred(ua) ^ ($urandom_range(0, 5) == 0), r, f,
            0, 0, 32'd0);
    end

`ifdef BRANCH_PRED_STATS_EN
    do_reset();
    check("stat_updates_rst", bus.stat_updates, 32'd0);
    drive(32'h8000, 1, 32'h1000, 32'h2000, 1, 1, 0, 0, 0, 32'd0);
    drive(32'h8000, 1, 32'h1000, 32'h2000, 1, 1, 0, 0, 0, 32'd0);
    drive(32'h8000, 1, 32'h1000, 32'h2000, 1, 0, 0, 0, 0, 32'd0);
    drive(32'h8000, 1, 32'h1040, 32'h2000, 0, 0, 0, 0, 0, 32'd0);
    check("plan_stat_updates", bus.stat_updates, 32'd4);
    check("plan_stat_mispredicts", bus.stat_mispredicts, 32'd1);
    check("plan_stat_hits", bus.stat_hits, 32'd2);
    do_reset();
    check("stat_updates_rst2", bus.stat_updates, 32'd0);
    check("stat_mispredicts_rst2", bus.stat_mispredicts, 32'd0);
    check("stat_hits_rst2", bus.stat_hits, 32'd0);
`else
    do_reset();
    lookc(32'h0000_1000, 0, 32'h0000_1004);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_predictor_btb.md
Name: branch_predictor_btb

Overview:
- Predictor-side endpoint of the predictor/pipeline interface.
- Fetch drives current_PC; block returns predict_taken and target_addr combinationally in the same cycle.
- Resolution stage drives update_predictor with the actual branch outcome; the block trains its tables on the next CLK edge.
- Direct-mapped branch target buffer with a 2-bit saturating counter per entry.

Parameters:
- ENTRIES, 16, BTB entry count; power of two, at least 2.
- IDX_W, $clog2(ENTRIES), index width (derived, not overridden).
- TAG_W, 30-IDX_W, stored tag width (derived).

Ports:
- CLK  input  1  core clock
- RST  input  1  asynchronous active-high reset
- current_PC  input  32  fetch PC being looked up
- predict_taken  output  1  1 = fetch should redirect to target_addr
- target_addr  output  32  predicted next PC
- update_predictor  input  1  strobe: one resolved branch this cycle
- update_addr  input  32  PC of the resolved branch
- update_target  input  32  resolved branch target (valid when branch_result=1)
- prediction  input  1  predict_taken value carried down the pipe with this branch
- branch_result  input  1  actual outcome, 1 = taken
- flush  input  1  synchronous invalidate of all entries (fence.i / context switch)

Behaviour:
- Interface decision: one clock CLK; reset RST is asynchronous and active-high.
- Entry fields: valid, tag[TAG_W], target[32], ctr[2].
- Lookup index = current_PC[IDX_W+1:2]; lookup tag = current_PC[31:IDX_W+2]. Update uses update_addr with the same slicing.
- Lookup is purely combinational, zero latency:
  - hit = valid & tag match.
  - predict_taken = hit & ctr[1].
  - target_addr = stored target when predict_taken, else current_PC + 32'd4 (wraps modulo 2^32).
- Counter states: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- Update on a CLK edge when update_predictor=1:
  - Update hit, taken: ctr increments, saturating at 11; target <= update_target.
  - Update hit, not taken: ctr decrements, saturating at 00; target unchanged.
  - Update miss, taken: allocate/overwrite entry. valid=1, tag=update tag, target=update_target, ctr=10.
  - Update miss, not taken: no state change.
- update_predictor=0: tables hold.
- Same-index lookup and update in one cycle: lookup returns pre-update contents; no bypass.
- flush=1 at a CLK edge: every valid bit clears. flush wins over a simultaneous update, so the update is dropped. ctr and target are not cleared.
- Reset, asynchronous: all valid=0, ctr=01, target=0.
  - Immediately after reset: predict_taken=0, target_addr=current_PC+4.
  - RST asserted mid-update discards the update.
- current_PC/update_addr bits [1:0] are ignored.
- Only entry storage and optional counters are sequential; outputs carry no registers.

Optional Feature:
- Macro BRANCH_PRED_STATS_EN.
- When defined, three outputs are added:
  - stat_updates [32]: count of cycles with update_predictor=1.
  - stat_mispredicts [32]: count of updates where prediction != branch_result.
  - stat_hits [32]: count of updates that hit the BTB.
- All three reset to 0 on RST, saturate at 32'hFFFFFFFF, and are not cleared by flush.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: release RST, current_PC=32'h0000_1000 -> predict_taken=0, target_addr=32'h0000_1004.
- Allocate: update_addr=32'h1000, branch_result=1, update_target=32'h2000 (ENTRIES=16). Next cycle current_PC=32'h1000 -> predict_taken=1, target_addr=32'h2000 (ctr=10).
- Hysteresis/saturation:
  - Two taken updates on 32'h1000 -> ctr=11.
  - One not-taken -> still predict_taken=1 (ctr=10).
  - Second not-taken -> predict_taken=0 (ctr=01).
  - Three more not-taken -> ctr stays 00.
- Alias/tag: entry at 32'h1000; lookup 32'h1040 (same index 0, different tag) -> predict_taken=0, target_addr=32'h1044. Taken update at 32'h1040, target 32'h3000 -> replaces entry; lookup 32'h1000 now misses.
- Simultaneous events:
  - Same-cycle lookup/update on index 0 -> lookup shows old value, new value appears next cycle.
  - flush with an update in the same cycle -> all lookups miss afterward.
  - Not-taken update on a miss -> no allocation.
- Stats (BRANCH_PRED_STATS_EN): 4 updates, 1 with prediction=1/branch_result=0, 2 hits -> stat_updates=4, stat_mispredicts=1, stat_hits=2; after RST all 0.
